tdm_demux_4x4: RTL and testbench
================================

TDM_DEMUX_4X4 -- requirements
Module: tdm_demux_4x4

Interface
REQ-001 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-002 SHALL have port: rst_n  input  1  asynchronous, active-low reset.
REQ-003 SHALL have port: inDado  input  4  time-multiplexed data word, slot order A,B,C,D.
REQ-004 SHALL have port: inValido  input  1  inDado valid this cycle.
REQ-005 SHALL have port: inInicio  input  1  frame start; meaningful only with inValido=1; marks slot A.
REQ-006 SHALL have port: inParidade  input  1  even-parity bit for inDado; ignored unless PARITY_CHECK_EN.
REQ-007 SHALL have ports: outA, outB, outC, outD  output  4 each  last committed frame, one register per channel.
REQ-008 SHALL have port: outQuadroOk  output  1  one-cycle pulse, frame committed.
REQ-009 SHALL have port: outErro  output  1  one-cycle pulse, frame discarded.
REQ-010 SHALL have port: outSlot_n  output  4  active-low one-hot strobe of slot written this cycle (bit0=A ... bit3=D); 4'b1111 when none.
REQ-011 SHALL have port: outOcupado  output  1  high while a frame is partially received.

Function
REQ-012 SHALL implement FSM with states IDLE and RECV plus 2-bit slot counter.
REQ-013 In IDLE: inValido=1 and inInicio=1 -> word stored to shadow A, slot=1, go RECV; inValido=1 and inInicio=0 -> word ignored, no pulse.
REQ-014 In RECV: each inValido=1 word with inInicio=0 -> stored to shadow[slot], slot increments; inValido=0 cycles are gaps, no timeout.
REQ-015 On the edge accepting slot D: outA..outC <= shadows, outD <= inDado, outQuadroOk=1 for the following cycle, go IDLE, slot=0.
REQ-016 Latency: outputs reflect a frame in the cycle after its slot-D word is sampled; outputs otherwise hold.
REQ-017 inInicio=1 with inValido=1 while in RECV: partial frame abandoned, outErro pulses, word stored as new slot A, slot=1, stay RECV.
REQ-018 outSlot_n registered: bit k low for exactly one cycle after slot k is accepted (including restart as A); never more than one bit low.
REQ-019 outOcupado=1 exactly when state is RECV.
REQ-020 outQuadroOk and outErro SHALL never be high in the same cycle; committed outputs never hold a mix of two frames.

Reset
REQ-021 rst_n low SHALL immediately force: state IDLE, slot 0, shadows and outA..outD 4'h0, outQuadroOk 0, outErro 0, outSlot_n 4'b1111, outOcupado 0.
REQ-022 Reset asserted mid-frame SHALL discard the partial frame with no outErro pulse.
REQ-023 First word after reset release SHALL be accepted only if it carries inInicio.

Configuration
REQ-024 Macro PARITY_CHECK_EN defined: any accepted word where inParidade != XOR(inDado) -> frame discarded, outErro pulses, go IDLE, outputs unchanged, no outSlot_n strobe for that word.
REQ-025 Macro PARITY_CHECK_EN undefined: inParidade ignored, no parity logic synthesized; all other behaviour identical.

Structure
REQ-026 Shared package SHALL hold constants NUM_SLOTS=4, DATA_W=4, the FSM state typedef, and slot indices SLOT_A..SLOT_D.
REQ-027 Sub-module tdm_slot_decode SHALL convert 2-bit slot index plus enable to the active-low one-hot outSlot_n pattern.

Verification
REQ-028 Reset, then words 3,5,9,C with inInicio on first -> outA=3, outB=5, outC=9, outD=C; outQuadroOk one pulse; outSlot_n sequence 1110,1101,1011,0111.
REQ-029 Same frame with inValido=0 gaps of 2 cycles between words -> identical outputs; outOcupado high from first word until commit.
REQ-030 Words 1,2 then inInicio with 7,8,9,A -> outErro pulse at restart; final outA..D = 7,8,9,A; outputs untouched before commit.
REQ-031 Words without inInicio in IDLE (4,4,4) -> no outputs change, no pulses, outSlot_n stays 1111.
REQ-032 PARITY_CHECK_EN: frame 3,5,9,C with wrong parity on word 9 -> outErro pulse, outputs hold previous frame; without macro same stimulus commits normally.
REQ-033 rst_n low after two words of a frame -> all outputs reset values at once, no outErro; next full frame commits correctly.

Source files
------------

// File: rtl/tdm_demux_4x4_pkg.sv
// ============================================================================
// tdm_demux_4x4_pkg : shared constants, FSM state type and slot indices
// Revision : 1.0
// ============================================================================
`default_nettype none

package tdm_demux_4x4_pkg;

  localparam int NUM_SLOTS = 4;
  localparam int DATA_W    = 4;

  typedef logic [0:0] state_t;
  localparam state_t ST_IDLE = 1'b0;
  localparam state_t ST_RECV = 1'b1;

  localparam logic [1:0] SLOT_A = 2'd0;
  localparam logic [1:0] SLOT_B = 2'd1;
  localparam logic [1:0] SLOT_C = 2'd2;
  localparam logic [1:0] SLOT_D = 2'd3;

  function automatic logic even_parity(input logic [DATA_W-1:0] d);
    return ^d;
  endfunction

endpackage

`default_nettype wire

// File: rtl/tdm_slot_decode.sv
// ============================================================================
// tdm_slot_decode : slot index + enable -> active-low one-hot slot strobe
// Revision : 1.0
// ============================================================================
`default_nettype none

module tdm_slot_decode
  import tdm_demux_4x4_pkg::*;
(
  input  logic [1:0]           slot_i,
  input  logic                 en_i,
  output logic [NUM_SLOTS-1:0] slot_n_o
);

  always_comb begin
    slot_n_o = '1;
    if (en_i) slot_n_o[slot_i] = 1'b0;
  end

endmodule

`default_nettype wire

// File: rtl/tdm_demux_4x4.sv
// ============================================================================
// tdm_demux_4x4 : 4-slot TDM demultiplexer with shadow registers and atomic
//                 frame commit. Optional parity check: define PARITY_CHECK_EN.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tdm_demux_4x4
  import tdm_demux_4x4_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] inDado,
  input  logic              inValido,
  input  logic              inInicio,
  input  logic              inParidade,
  output logic [DATA_W-1:0] outA,
  output logic [DATA_W-1:0] outB,
  output logic [DATA_W-1:0] outC,
  output logic [DATA_W-1:0] outD,
  output logic              outQuadroOk,
  output logic              outErro,
  output logic [3:0]        outSlot_n,
  output logic              outOcupado
);

  state_t            state_q, state_d;
  logic [1:0]        slot_q, slot_d;
  logic [DATA_W-1:0] shA_q, shA_d, shB_q, shB_d, shC_q, shC_d;
  logic [DATA_W-1:0] outA_q, outA_d, outB_q, outB_d, outC_q, outC_d, outD_q, outD_d;
  logic              ok_q, ok_d, err_q, err_d;
  logic [3:0]        slot_n_q, w_slot_n;
  logic              w_strobe_en;
  logic [1:0]        w_strobe_idx;
  logic              w_par_bad;

`ifdef PARITY_CHECK_EN
  assign w_par_bad = (inParidade != even_parity(inDado));
`else
  logic w_unused_par;
  assign w_unused_par = inParidade;
  assign w_par_bad    = 1'b0;
`endif

  always_comb begin
    state_d      = state_q;
    slot_d       = slot_q;
    shA_d        = shA_q;
    shB_d        = shB_q;
    shC_d        = shC_q;
    outA_d       = outA_q;
    outB_d       = outB_q;
    outC_d       = outC_q;
    outD_d       = outD_q;
    ok_d         = 1'b0;
    err_d        = 1'b0;
    w_strobe_en  = 1'b0;
    w_strobe_idx = slot_q;

    if (inValido) begin
      if (state_q == ST_IDLE) begin
        if (inInicio) begin
          if (w_par_bad) begin
            err_d = 1'b1;
          end else begin
            shA_d        = inDado;
            slot_d       = SLOT_B;
            state_d      = ST_RECV;
            w_strobe_en  = 1'b1;
            w_strobe_idx = SLOT_A;
          end
        end
      end else begin
        if (w_par_bad) begin
          err_d   = 1'b1;
          state_d = ST_IDLE;
          slot_d  = SLOT_A;
        end else if (inInicio) begin
          // Restart: the new word becomes slot A of a fresh frame
          err_d        = 1'b1;
          shA_d        = inDado;
          slot_d       = SLOT_B;
          w_strobe_en  = 1'b1;
          w_strobe_idx = SLOT_A;
        end else if (slot_q == SLOT_D) begin
          outA_d      = shA_q;
          outB_d      = shB_q;
          outC_d      = shC_q;
          outD_d      = inDado;
          ok_d        = 1'b1;
          state_d     = ST_IDLE;
          slot_d      = SLOT_A;
          w_strobe_en = 1'b1;
        end else begin
          case (slot_q)
            SLOT_A:  shA_d = inDado;
            SLOT_B:  shB_d = inDado;
            SLOT_C:  shC_d = inDado;
            default: ;
          endcase
          slot_d      = slot_q + 2'd1;
          w_strobe_en = 1'b1;
        end
      end
    end
  end

  tdm_slot_decode u_slot_decode (
    .slot_i   (w_strobe_idx),
    .en_i     (w_strobe_en),
    .slot_n_o (w_slot_n)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      slot_q   <= SLOT_A;
      shA_q    <= '0;
      shB_q    <= '0;
      shC_q    <= '0;
      outA_q   <= '0;
      outB_q   <= '0;
      outC_q   <= '0;
      outD_q   <= '0;
      ok_q     <= 1'b0;
      err_q    <= 1'b0;
      slot_n_q <= 4'b1111;
    end else begin
      state_q  <= state_d;
      slot_q   <= slot_d;
      shA_q    <= shA_d;
      shB_q    <= shB_d;
      shC_q    <= shC_d;
      outA_q   <= outA_d;
      outB_q   <= outB_d;
      outC_q   <= outC_d;
      outD_q   <= outD_d;
      ok_q     <= ok_d;
      err_q    <= err_d;
      slot_n_q <= w_slot_n;
    end
  end

  assign outA        = outA_q;
  assign outB        = outB_q;
  assign outC        = outC_q;
  assign outD        = outD_q;
  assign outQuadroOk = ok_q;
  assign outErro     = err_q;
  assign outSlot_n   = slot_n_q;
  assign outOcupado  = (state_q == ST_RECV);

endmodule

`default_nettype wire

// File: tb/tb_tdm_demux_4x4.sv
// ============================================================================
// tb_tdm_demux_4x4 : scoreboard bench for tdm_demux_4x4 (PARITY_CHECK_EN aware)
// Revision : 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_tdm_demux_4x4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] inDado;
  logic       inValido, inInicio, inParidade;
  logic [3:0] outA, outB, outC, outD;
  logic       outQuadroOk, outErro, outOcupado;
  logic [3:0] outSlot_n;

  always #5 clk = ~clk;

  tdm_demux_4x4 dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .inDado      (inDado),
    .inValido    (inValido),
    .inInicio    (inInicio),
    .inParidade  (inParidade),
    .outA        (outA),
    .outB        (outB),
    .outC        (outC),
    .outD        (outD),
    .outQuadroOk (outQuadroOk),
    .outErro     (outErro),
    .outSlot_n   (outSlot_n),
    .outOcupado  (outOcupado)
  );

  typedef struct {
    bit         err;
    logic [3:0] a, b, c, d;
  } ev_t;

  ev_t        evq[$];
  logic [3:0] sq[$];
  logic [3:0] cur_a = 4'h0, cur_b = 4'h0, cur_c = 4'h0, cur_d = 4'h0;
  int         n_chk = 0;
  int         n_err = 0;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic exp_commit(input logic [3:0] a, b, c, d);
    ev_t e;
    e.err = 1'b0; e.a = a; e.b = b; e.c = c; e.d = d;
    evq.push_back(e);
    cur_a = a; cur_b = b; cur_c = c; cur_d = d;
  endtask

  task automatic exp_error();
    ev_t e;
    e.err = 1'b1; e.a = cur_a; e.b = cur_b; e.c = cur_c; e.d = cur_d;
    evq.push_back(e);
  endtask

  task automatic send(input logic [3:0] d, input logic ini, input logic bad_par);
    inDado     = d;
    inValido   = 1'b1;
    inInicio   = ini;
    inParidade = (^d) ^ bad_par;
    @(posedge clk); #1;
    inValido   = 1'b0;
    inInicio   = 1'b0;
  endtask

  task automatic gap(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic chk_outs(input string name, input logic [3:0] a, b, c, d);
    chk(name, {outA, outB, outC, outD}, {a, b, c, d});
  endtask

  // Monitor: any pulse or strobe must match the head of its queue
  always @(negedge clk) begin
    if (rst_n) begin
      if (outQuadroOk || outErro) begin
        chk("ok_err_exclusive", {15'd0, outQuadroOk & outErro}, 16'd0);
        if (evq.size() == 0) begin
          n_chk++; n_err++;
          $display("FAIL unexpected_event: ok=%b err=%b expected none", outQuadroOk, outErro);
        end else begin
          ev_t e;
          e = evq.pop_front();
          chk("event_kind_err", {15'd0, outErro}, {15'd0, e.err});
          chk(e.err ? "outs_on_error" : "outs_on_commit",
              {outA, outB, outC, outD}, {e.a, e.b, e.c, e.d});
        end
      end
      if (outSlot_n != 4'hF) begin
        if (sq.size() == 0) begin
          n_chk++; n_err++;
          $display("FAIL unexpected_strobe: got %b expected 1111", outSlot_n);
        end else begin
          chk("slot_strobe", {12'd0, outSlot_n}, {12'd0, sq.pop_front()});
        end
      end
    end
  end

  initial begin
    rst_n = 1'b0; inDado = 4'h0; inValido = 1'b0; inInicio = 1'b0; inParidade = 1'b0;
    repeat (3) @(posedge clk); #1;
    chk_outs("reset_outs", 4'h0, 4'h0, 4'h0, 4'h0);
    chk("reset_flags", {12'd0, outQuadroOk, outErro, outOcupado, 1'b0}, 16'd0);
    chk("reset_slot_n", {12'd0, outSlot_n}, 16'h000F);
    rst_n = 1'b1;
    gap(1);

    // Basic frame, back to back
    sq.push_back(4'b1110); sq.push_back(4'b1101); sq.push_back(4'b1011); sq.push_back(4'b0111);
    exp_commit(4'h3, 4'h5, 4'h9, 4'hC);
    send(4'h3, 1, 0); send(4'h5, 0, 0); send(4'h9, 0, 0); send(4'hC, 0, 0);
    gap(3);
    chk_outs("hold_after_frame1", 4'h3, 4'h5, 4'h9, 4'hC);
    chk("idle_not_busy", {15'd0, outOcupado}, 16'd0);

    // Gapped frame with different data
    sq.push_back(4'b1110); sq.push_back(4'b1101); sq.push_back(4'b1011); sq.push_back(4'b0111);
    send(4'h6, 1, 0);
    chk("busy_after_first", {15'd0, outOcupado}, 16'd1);
    gap(2); send(4'hA, 0, 0);
    gap(1);
    chk("busy_in_gap", {15'd0, outOcupado}, 16'd1);
    gap(1); send(4'h1, 0, 0);
    gap(2);
    chk_outs("hold_mid_gapped", 4'h3, 4'h5, 4'h9, 4'hC);
    exp_commit(4'h6, 4'hA, 4'h1, 4'hF);
    send(4'hF, 0, 0);
    chk("not_busy_after_commit", {15'd0, outOcupado}, 16'd0);
    gap(3);

    // Restart mid-frame
    sq.push_back(4'b1110); sq.push_back(4'b1101);
    send(4'h1, 1, 0); send(4'h2, 0, 0);
    exp_error();
    sq.push_back(4'b1110); sq.push_back(4'b1101); sq.push_back(4'b1011); sq.push_back(4'b0111);
    send(4'h7, 1, 0); send(4'h8, 0, 0); send(4'h9, 0, 0);
    chk_outs("untouched_before_commit", 4'h6, 4'hA, 4'h1, 4'hF);
    exp_commit(4'h7, 4'h8, 4'h9, 4'hA);
    send(4'hA, 0, 0);
    gap(3);

    // Non-start words while idle are ignored
    send(4'h4, 0, 0); send(4'h4, 0, 0); send(4'h4, 0, 0);
    gap(2);
    chk_outs("idle_words_ignored", 4'h7, 4'h8, 4'h9, 4'hA);
    chk("idle_words_not_busy", {15'd0, outOcupado}, 16'd0);

    // Wrong parity on the third word
`ifdef PARITY_CHECK_EN
    sq.push_back(4'b1110); sq.push_back(4'b1101);
    send(4'h3, 1, 0); send(4'h5, 0, 0);
    exp_error();
    send(4'h9, 0, 1); send(4'hC, 0, 0);
    gap(2);
    chk_outs("parity_hold", 4'h7, 4'h8, 4'h9, 4'hA);
`else
    sq.push_back(4'b1110); sq.push_back(4'b1101); sq.push_back(4'b1011); sq.push_back(4'b0111);
    send(4'h3, 1, 0); send(4'h5, 0, 0);
    exp_commit(4'h3, 4'h5, 4'h9, 4'hC);
    send(4'h9, 0, 1); send(4'hC, 0, 0);
    gap(2);
    chk_outs("parity_ignored", 4'h3, 4'h5, 4'h9, 4'hC);
`endif
    gap(2);

    // Reset in the middle of a frame
    sq.push_back(4'b1110); sq.push_back(4'b1101);
    send(4'h1, 1, 0); send(4'h2, 0, 0);
    @(negedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk_outs("midreset_outs", 4'h0, 4'h0, 4'h0, 4'h0);
    chk("midreset_flags", {12'd0, outQuadroOk, outErro, outOcupado, 1'b0}, 16'd0);
    chk("midreset_slot_n", {12'd0, outSlot_n}, 16'h000F);
    cur_a = 4'h0; cur_b = 4'h0; cur_c = 4'h0; cur_d = 4'h0;
    @(negedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    send(4'hD, 0, 0);
    chk("first_word_needs_start", {15'd0, outOcupado}, 16'd0);
    sq.push_back(4'b1110); sq.push_back(4'b1101); sq.push_back(4'b1011); sq.push_back(4'b0111);
    exp_commit(4'h4, 4'hB, 4'hE, 4'h2);
    send(4'h4, 1, 0); send(4'hB, 0, 0); send(4'hE, 0, 0); send(4'h2, 0, 0);
    gap(3);
    chk_outs("post_reset_frame", 4'h4, 4'hB, 4'hE, 4'h2);

    chk("events_drained", evq.size(), 16'd0);
    chk("strobes_drained", sq.size(), 16'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

`default_nettype wire
